// File: rtl/prog_sequencer.sv
// Program sequencer: fetches 16-bit instructions (and mvi immediates) from a
// synchronous program memory and paces the processor with Run/Done handshakes.
module prog_sequencer #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned LAST_ADDR = 255,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic [15:0]       i_mem_data,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_rd,
   output logic [15:0]       o_din,
   output logic              o_run,
   input  logic              i_done,
   output logic              o_busy,
   output logic              o_halted,
   output logic              o_timeout,
   output logic [15:0]       o_instr_count
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
   localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(LAST_ADDR);
   localparam logic [2:0] OP_MVI = 3'b001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_EXEC,
      S_RETIRE,
      S_HALT
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [15:0]       r_count;
   logic              r_timeout;
   logic              r_stop_pend;
   logic [WD_W-1:0]   r_wdog;
   logic [15:0]       r_instr;

   logic              w_busy;
   logic              w_mvi_in;
   logic              w_mvi_r;
   logic              w_pc_last;
   logic [ADDR_W-1:0] w_pc_p1;
   logic [ADDR_W:0]   w_npc;
   logic              w_wd_exp;
   logic              w_stop;

   assign w_busy    = (r_state != S_IDLE) && (r_state != S_HALT);
   assign w_mvi_in  = (i_mem_data[15:13] == OP_MVI);
   assign w_mvi_r   = (r_instr[15:13] == OP_MVI);
   assign w_pc_last = ({1'b0, r_pc} == LAST);
   assign w_pc_p1   = r_pc + ADDR_W'(1);
   // One extra bit so a step past the top of memory halts instead of wrapping
   assign w_npc     = {1'b0, r_pc}
                    + (w_mvi_r ? (ADDR_W + 1)'(2) : (ADDR_W + 1)'(1));
   assign w_wd_exp  = ((r_wdog + WD_W'(1)) == WD_MAX);
   assign w_stop    = r_stop_pend | i_stop;

   assign o_busy        = w_busy;
   assign o_halted      = (r_state == S_HALT);
   assign o_timeout     = r_timeout;
   assign o_instr_count = r_count;

   always_comb begin
      o_mem_addr = '0;
      o_mem_rd   = 1'b0;
      o_din      = '0;
      o_run      = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            o_mem_addr = r_pc;
            o_mem_rd   = 1'b1;
         end
         S_ISSUE: begin
            o_din = i_mem_data;
            o_run = 1'b1;
            if (w_mvi_in && !w_pc_last) begin
               o_mem_addr = w_pc_p1;
               o_mem_rd   = 1'b1;
            end
         end
         S_EXEC: begin
            o_run = 1'b1;
            // Immediate read held open so MemData stays valid all of EXEC
            if (w_mvi_r) begin
               o_din      = i_mem_data;
               o_mem_addr = w_pc_p1;
               o_mem_rd   = 1'b1;
            end else begin
               o_din = r_instr;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_count     <= '0;
         r_timeout   <= 1'b0;
         r_stop_pend <= 1'b0;
         r_wdog      <= '0;
         r_instr     <= '0;
      end else begin
         if (i_stop && w_busy) r_stop_pend <= 1'b1;
         unique case (r_state)
            S_IDLE, S_HALT: begin
               r_stop_pend <= 1'b0;
               if (i_start) begin
                  r_pc      <= '0;
                  r_count   <= '0;
                  r_timeout <= 1'b0;
                  r_wdog    <= '0;
                  r_state   <= S_FETCH;
               end
            end
            S_FETCH: r_state <= S_ISSUE;
            S_ISSUE: begin
               r_instr <= i_mem_data;
               r_wdog  <= '0;
               // mvi with no room for its immediate is treated as an abort
               if (w_mvi_in && w_pc_last) begin
                  r_timeout   <= 1'b1;
                  r_stop_pend <= 1'b0;
                  r_state     <= S_HALT;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (i_done) begin
                  r_wdog  <= '0;
                  r_state <= S_RETIRE;
               end else if (w_wd_exp) begin
                  r_wdog      <= '0;
                  r_timeout   <= 1'b1;
                  r_stop_pend <= 1'b0;
                  r_state     <= S_HALT;
               end else begin
                  r_wdog <= r_wdog + WD_W'(1);
               end
            end
            S_RETIRE: begin
               r_count <= r_count + 16'd1;
               r_pc    <= w_npc[ADDR_W-1:0];
               if (w_stop || (w_npc > LAST)) begin
                  r_stop_pend <= 1'b0;
                  r_state     <= S_HALT;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: memory + processor models, fetch scoreboard
// built from a reference walk of the program.
module tb_prog_sequencer;

   localparam int LAST = 3;
   localparam int TMO  = 15;

   typedef struct {
      int          addr;
      logic [15:0] iw;
      logic [15:0] din;
      int          runlen;
      int          gap;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic        stop  = 1'b0;
   logic        done  = 1'b0;
   logic [15:0] mem_q = '0;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [15:0] din;
   logic        run;
   logic        busy;
   logic        halted;
   logic        tmo;
   logic [15:0] icnt;

   logic [15:0] mem [0:255];

   exp_t sb[$];
   exp_t cur;
   bit   cur_v   = 0;
   bit   exp_to  = 0;
   int   n_chk   = 0;
   int   n_err   = 0;
   int   run_len = 0;
   int   n_fetch = 0;
   int   cyc     = 0;
   int   last_f  = 0;
   int   dl_cur  = 0;
   int   max_rd  = 0;
   int   exp_cnt = 0;

   prog_sequencer #(
      .ADDR_W(8),
      .LAST_ADDR(LAST),
      .TIMEOUT(TMO)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_start(start),
      .i_stop(stop),
      .i_mem_data(mem_q),
      .o_mem_addr(mem_addr),
      .o_mem_rd(mem_rd),
      .o_din(din),
      .o_run(run),
      .i_done(done),
      .o_busy(busy),
      .o_halted(halted),
      .o_timeout(tmo),
      .o_instr_count(icnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (mem_rd) mem_q <= mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Monitor and processor model: Done raised on the dl-th EXEC cycle
   always @(negedge clk) begin
      if (rst) begin
         cur_v   = 0;
         run_len = 0;
         done    = 1'b0;
      end else begin
         if (mem_rd && int'(mem_addr) > max_rd) max_rd = int'(mem_addr);
         if (mem_rd && !run) begin
            n_fetch++;
            if (sb.size() == 0) begin
               chk("fetch_unexp", 32'(sb.size()), 1);
               cur_v = 0;
            end else begin
               cur   = sb.pop_front();
               cur_v = 1;
               chk("fetch_addr", 32'(mem_addr), 32'(cur.addr));
               if (cur.gap != 0)
                  chk("fetch_gap", 32'(cyc - last_f), 32'(cur.gap));
            end
            last_f = cyc;
         end
         if (run) begin
            run_len++;
            if (cur_v && run_len == 1)
               chk("issue_din", 32'(din), 32'(cur.iw));
            else if (cur_v)
               chk("exec_din", 32'(din), 32'(cur.din));
         end else if (run_len != 0) begin
            if (cur_v) chk("run_len", 32'(run_len), 32'(cur.runlen));
            cur_v   = 0;
            run_len = 0;
         end
         done = run && (dl_cur != 0) && (run_len == dl_cur + 1);
      end
   end

   task automatic load(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
      mem[0] = a;
      mem[1] = b;
      mem[2] = c;
      mem[3] = d;
   endtask

   task automatic build_model(input int dl, input int sidx);
      int   pc;
      int   n;
      int   prev_rl;
      bit   mvi;
      exp_t e;
      pc      = 0;
      n       = 0;
      prev_rl = 0;
      sb.delete();
      exp_cnt = 0;
      exp_to  = 0;
      forever begin
         mvi      = (mem[pc][15:13] == 3'b001);
         e.addr   = pc;
         e.iw     = mem[pc];
         e.din    = mvi ? mem[pc+1] : mem[pc];
         e.gap    = (n == 0) ? 0 : prev_rl + 2;
         if (mvi && pc == LAST) begin
            e.runlen = 1;
            exp_to   = 1;
            sb.push_back(e);
            break;
         end
         if (dl == 0) begin
            e.runlen = 1 + TMO;
            exp_to   = 1;
            sb.push_back(e);
            break;
         end
         e.runlen = dl + 1;
         sb.push_back(e);
         exp_cnt++;
         prev_rl = e.runlen;
         pc += mvi ? 2 : 1;
         if (n == sidx || pc > LAST) break;
         n++;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
   endtask

   task automatic run_prog(input int dl, input int sidx,
                           input bit do_rst, input bit dup);
      if (do_rst) begin
         rst = 1'b1;
         @(negedge clk); #1 rst = 1'b0;
      end
      build_model(dl, sidx);
      n_fetch = 0;
      max_rd  = 0;
      dl_cur  = dl;
      pulse_start();
      for (int c = 0; c < 400 && !halted; c++) begin
         @(negedge clk); #1;
         stop  = (sidx >= 0 && n_fetch == sidx + 1 && run_len == 2);
         start = (dup && n_fetch == 1 && run_len == 2);
      end
      stop  = 1'b0;
      start = 1'b0;
      chk("halted", 32'(halted), 1);
      chk("busy", 32'(busy), 0);
      chk("run", 32'(run), 0);
      chk("count", 32'(icnt), 32'(exp_cnt));
      chk("timeout", 32'(tmo), 32'(exp_to));
      chk("sb_left", 32'(sb.size()), 0);
      chk("no_rd_past_last", 32'(max_rd <= LAST), 1);
   endtask

   task automatic chk_rst_outs(input string tag);
      chk({tag, "_run"}, 32'(run), 0);
      chk({tag, "_rd"}, 32'(mem_rd), 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_din"}, 32'(din), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_halted"}, 32'(halted), 0);
      chk({tag, "_tmo"}, 32'(tmo), 0);
      chk({tag, "_cnt"}, 32'(icnt), 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      @(negedge clk); #1;
      chk_rst_outs("rst");
      @(negedge clk); #1 rst = 1'b0;
      @(negedge clk); #1;
      chk("idle_busy", 32'(busy), 0);

      load(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      run_prog(2, 1, 0, 0);
      run_prog(1, -1, 1, 1);
      load(16'h2000, 16'h00AB, 16'h0000, 16'h0000);
      run_prog(3, -1, 1, 0);
      load(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      run_prog(0, -1, 1, 0);
      load(16'h2000, 16'h0055, 16'h1234, 16'h4321);
      run_prog(2, -1, 0, 0);
      load(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      run_prog(4, 2, 1, 0);
      load(16'h0000, 16'h0000, 16'h0000, 16'h2000);
      run_prog(1, -1, 1, 0);
      for (int r = 0; r < 4; r++) begin
         load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         run_prog(int'($urandom_range(1, 6)), -1, 1, 0);
      end

      load(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      build_model(3, -1);
      n_fetch = 0;
      dl_cur  = 3;
      pulse_start();
      for (int c = 0; c < 100 && !(n_fetch == 2 && run_len == 2); c++) begin
         @(negedge clk); #1;
      end
      chk("mid_exec_reached", 32'(n_fetch), 2);
      chk("mid_exec_cnt", 32'(icnt), 1);
      rst = 1'b1;
      #1;
      chk_rst_outs("async_rst");
      @(negedge clk); #1 rst = 1'b0;
      run_prog(2, -1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width.
REQ-002 Parameter LAST_ADDR, default 255, highest legal program address.
REQ-003 Parameter TIMEOUT, default 15, max EXEC cycles without Done before abort.
REQ-004 Clock  in  1  sole clock; all state updates on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset (one clock; reset asynchronous, active-high).
REQ-006 Start  in  1  single-cycle pulse; begins a program run at address 0.
REQ-007 Stop  in  1  single-cycle pulse; requests halt after the current instruction.
REQ-008 MemData  in  16  synchronous program-memory read data, valid one cycle after MemRd.
REQ-009 MemAddr  out  ADDR_W  program-memory read address.
REQ-010 MemRd  out  1  program-memory read enable.
REQ-011 DIN  out  16  instruction/immediate word driven to the processor.
REQ-012 Run  out  1  processor run enable; held high for a whole instruction.
REQ-013 Done  in  1  processor instruction-complete flag.
REQ-014 Busy  out  1  high in any state other than IDLE and HALT.
REQ-015 Halted  out  1  high in HALT.
REQ-016 Timeout  out  1  sticky; set on watchdog abort.
REQ-017 InstrCount  out  16  retired-instruction count for the current run.

Function
REQ-018 States SHALL be IDLE, FETCH, ISSUE, EXEC, RETIRE, HALT; PC is an ADDR_W-bit register.
REQ-019 IDLE: Run=0, MemRd=0; Start -> PC=0, InstrCount=0, Timeout=0, go FETCH; Stop ignored.
REQ-020 FETCH (1 cycle): MemAddr=PC, MemRd=1; go ISSUE.
REQ-021 ISSUE (1 cycle): capture MemData into instr register; DIN=MemData; Run=1.
REQ-022 ISSUE: opcode = MemData[15:13]; if 3'b001 (mvi), MemAddr=PC+1, MemRd=1; go EXEC.
REQ-023 EXEC: Run=1; DIN=MemData for mvi (MemAddr=PC+1, MemRd=1 held stable), else DIN=instr register, MemRd=0.
REQ-024 EXEC: Done sampled high -> go RETIRE; watchdog counter increments each EXEC cycle and clears on leaving EXEC.
REQ-025 EXEC: watchdog reaching TIMEOUT without Done -> Timeout=1, go HALT; Done and timeout in the same cycle -> Done wins.
REQ-026 RETIRE (1 cycle): Run=0; InstrCount+=1 (wraps at 16 bits); PC+=2 for mvi, else PC+=1.
REQ-027 RETIRE: go HALT if Stop pending or next PC > LAST_ADDR (computed ADDR_W+1 bits, no wrap); else go FETCH.
REQ-028 Stop pulse in any Busy state SHALL be latched as pending; cleared on entering HALT or IDLE.
REQ-029 HALT: Run=0, MemRd=0, PC/InstrCount/Timeout held; Start -> behave as REQ-019 start.
REQ-030 Run SHALL drop to 0 for at least one cycle (RETIRE) between consecutive instructions.
REQ-031 Instruction latency, non-mvi with Done after k EXEC cycles: FETCH->FETCH = k+3 cycles.
REQ-032 mvi at PC=LAST_ADDR: immediate read of LAST_ADDR+1 SHALL NOT be issued; go HALT with Timeout=1 without entering EXEC.
REQ-033 Start while Busy SHALL be ignored.

Reset
REQ-034 Reset high SHALL asynchronously force state=IDLE, PC=0, InstrCount=0, Timeout=0, Stop-pending=0, watchdog=0, instr register=0.
REQ-035 During and after reset: Run=0, MemRd=0, MemAddr=0, DIN=0, Busy=0, Halted=0.
REQ-036 Reset mid-EXEC SHALL drop Run in the same cycle; no RETIRE or count update occurs.

Verification
REQ-037 Mem[0]=16'h0000 (mv), Start, Done 2 cycles after ISSUE -> Run high 3 cycles, PC=1, InstrCount=1, FETCH at addr 1.
REQ-038 Mem[0]=16'h2000 (mvi), Mem[1]=16'h00AB -> DIN=16'h00AB throughout EXEC, PC=2 after RETIRE.
REQ-039 Processor never asserts Done -> after 15 EXEC cycles Timeout=1, Halted=1, Run=0, InstrCount=0.
REQ-040 Stop pulse during EXEC of instr at PC=3 -> instruction retires, InstrCount increments, Halted=1, PC=4.
REQ-041 LAST_ADDR=3, four non-mvi instructions -> Halted=1 after 4th retire, PC=4, InstrCount=4, no read of address 4.
REQ-042 Reset asserted mid-EXEC, then Start -> all outputs at reset values, fetch restarts at address 0, InstrCount=0.
